// File: rtl/sram_fifo_sync.sv
// Show-ahead FIFO over an external 1r1w sync SRAM; 2-cycle push-to-head latency, 1 with SRAM_FIFO_BYPASS_EN.
// Push dropped when full; the holding register hides SRAM read latency so pops sustain one per cycle.
module sram_fifo_sync #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 256,
  parameter int W_ADDR  = $clog2(DEPTH),
  parameter int W_LEVEL = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  output logic               full,
  input  logic               pop,
  output logic [WIDTH-1:0]   rdata,
  output logic               empty,
  output logic [W_LEVEL-1:0] level,
  output logic [W_ADDR-1:0]  ram_waddr,
  output logic [WIDTH-1:0]   ram_wdata,
  output logic               ram_wen,
  output logic [W_ADDR-1:0]  ram_raddr,
  output logic               ram_ren,
  input  logic [WIDTH-1:0]   ram_rdata
);

  localparam logic [W_ADDR-1:0]  LAST_ADDR = W_ADDR'(DEPTH - 1);
  localparam logic [W_LEVEL-1:0] FULL_LVL  = W_LEVEL'(DEPTH);

  logic [W_ADDR-1:0]  wptr, rptr;
  logic [W_LEVEL-1:0] mem_count;
  logic               rd_pending, hold_valid;
  logic [WIDTH-1:0]   hold_data;
  logic               head_valid, push_acc, pop_eff, bypass;

  assign head_valid = rd_pending | hold_valid;
  assign empty      = !head_valid;
  assign rdata      = rd_pending ? ram_rdata : hold_data;
  assign level      = mem_count + W_LEVEL'(head_valid);
  assign full       = (level == FULL_LVL);

  assign push_acc = push && !full;
  assign pop_eff  = pop && head_valid;

`ifdef SRAM_FIFO_BYPASS_EN
  // Only legal when nothing older sits in the SRAM or in flight.
  assign bypass = push_acc && (mem_count == '0) && !rd_pending && (!hold_valid || pop_eff);
`else
  assign bypass = 1'b0;
`endif

  assign ram_wen   = push_acc && !bypass;
  assign ram_waddr = wptr;
  assign ram_wdata = wdata;
  assign ram_ren   = (mem_count != '0) && (!head_valid || pop_eff);
  assign ram_raddr = rptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      mem_count  <= '0;
      rd_pending <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (ram_wen) wptr <= (wptr == LAST_ADDR) ? '0 : wptr + W_ADDR'(1);
      if (ram_ren) rptr <= (rptr == LAST_ADDR) ? '0 : rptr + W_ADDR'(1);
      mem_count  <= mem_count + W_LEVEL'(ram_wen) - W_LEVEL'(ram_ren);
      rd_pending <= ram_ren;
      // A read landing without a pop parks in the holding register.
      if (bypass) begin
        hold_data  <= wdata;
        hold_valid <= 1'b1;
      end else if (rd_pending && !pop_eff) begin
        hold_data  <= ram_rdata;
        hold_valid <= 1'b1;
      end else if (pop_eff) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_fifo_sync.sv
// Directed bench for sram_fifo_sync: three instances (DEPTH 8, 5, 4) each backed by a behavioural SRAM.
module tb_sram_fifo_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // DEPTH=8 instance
  logic       push8 = 1'b0, pop8 = 1'b0;
  logic [7:0] wdata8 = '0;
  logic       full8, empty8, wen8, ren8;
  logic [7:0] rdata8, ram_wdata8, ram_rdata8;
  logic [3:0] level8;
  logic [2:0] waddr8, raddr8;
  logic [7:0] mem8 [8];

  sram_fifo_sync #(.WIDTH(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .push(push8), .wdata(wdata8), .full(full8),
    .pop(pop8), .rdata(rdata8), .empty(empty8), .level(level8),
    .ram_waddr(waddr8), .ram_wdata(ram_wdata8), .ram_wen(wen8),
    .ram_raddr(raddr8), .ram_ren(ren8), .ram_rdata(ram_rdata8));

  always_ff @(posedge clk) begin
    if (wen8) mem8[waddr8] <= ram_wdata8;
    if (ren8) ram_rdata8 <= mem8[raddr8];
  end

  // DEPTH=5 instance
  logic       push5 = 1'b0, pop5 = 1'b0;
  logic [7:0] wdata5 = '0;
  logic       full5, empty5, wen5, ren5;
  logic [7:0] rdata5, ram_wdata5, ram_rdata5;
  logic [2:0] level5;
  logic [2:0] waddr5, raddr5;
  logic [7:0] mem5 [8];

  sram_fifo_sync #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .push(push5), .wdata(wdata5), .full(full5),
    .pop(pop5), .rdata(rdata5), .empty(empty5), .level(level5),
    .ram_waddr(waddr5), .ram_wdata(ram_wdata5), .ram_wen(wen5),
    .ram_raddr(raddr5), .ram_ren(ren5), .ram_rdata(ram_rdata5));

  always_ff @(posedge clk) begin
    if (wen5) mem5[waddr5] <= ram_wdata5;
    if (ren5) ram_rdata5 <= mem5[raddr5];
  end

  // DEPTH=4 instance
  logic       push4 = 1'b0, pop4 = 1'b0;
  logic [7:0] wdata4 = '0;
  logic       full4, empty4, wen4, ren4;
  logic [7:0] rdata4, ram_wdata4, ram_rdata4;
  logic [2:0] level4;
  logic [1:0] waddr4, raddr4;
  logic [7:0] mem4 [4];

  sram_fifo_sync #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .push(push4), .wdata(wdata4), .full(full4),
    .pop(pop4), .rdata(rdata4), .empty(empty4), .level(level4),
    .ram_waddr(waddr4), .ram_wdata(ram_wdata4), .ram_wen(wen4),
    .ram_raddr(raddr4), .ram_ren(ren4), .ram_rdata(ram_rdata4));

  always_ff @(posedge clk) begin
    if (wen4) mem4[waddr4] <= ram_wdata4;
    if (ren4) ram_rdata4 <= mem4[raddr4];
  end

  initial begin
    int nxt;
    int got;
    bit seen;

    // Reset
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_empty", 32'(empty8), 1);
    check("rst_full", 32'(full8), 0);
    check("rst_level", 32'(level8), 0);
    check("rst_rdata", 32'(rdata8), 0);
    check("rst_wen", 32'(wen8), 0);
    check("rst_ren", 32'(ren8), 0);
    check("rst_waddr", 32'(waddr8), 0);
    check("rst_raddr", 32'(raddr8), 0);

    // Pop while empty
    pop8 = 1'b1;
    #1;
    check("empty_pop_ren", 32'(ren8), 0);
    step();
    pop8 = 1'b0;
    check("empty_pop_level", 32'(level8), 0);
    check("empty_pop_empty", 32'(empty8), 1);

    // Latency from empty
    push8 = 1'b1; wdata8 = 8'hA5;
    step();
    push8 = 1'b0;
`ifdef SRAM_FIFO_BYPASS_EN
    check("lat_n1_empty", 32'(empty8), 0);
`else
    check("lat_n1_empty", 32'(empty8), 1);
    step();
`endif
    check("lat_empty", 32'(empty8), 0);
    check("lat_rdata", 32'(rdata8), 32'hA5);
    pop8 = 1'b1;
    step();
    pop8 = 1'b0;
    check("lat_drained", 32'(empty8), 1);
    check("lat_level", 32'(level8), 0);

    // Fill and drain
    for (int i = 0; i < 8; i++) begin
      push8 = 1'b1; wdata8 = 8'(i);
      step();
    end
    push8 = 1'b0;
    check("fill_full", 32'(full8), 1);
    check("fill_level", 32'(level8), 8);
    push8 = 1'b1; wdata8 = 8'hFF;
    #1;
    check("fill_drop_wen", 32'(wen8), 0);
    step();
    push8 = 1'b0;
    check("fill_drop_level", 32'(level8), 8);
    for (int i = 0; i < 8; i++) begin
      check("drain_empty", 32'(empty8), 0);
      check("drain_data", 32'(rdata8), i);
      pop8 = 1'b1;
      step();
    end
    pop8 = 1'b0;
    check("drain_done_empty", 32'(empty8), 1);
    check("drain_done_level", 32'(level8), 0);

    // Streaming: push 1..100, pop whenever data is present
    nxt = 1; got = 0;
    for (int c = 0; c < 400 && got < 100; c++) begin
      if (got > 0) check("stream_gap", 32'(empty8), 0);
      push8 = (nxt <= 100); wdata8 = 8'(nxt);
      pop8 = !empty8;
      if (!empty8) begin
        check("stream_data", 32'(rdata8), got + 1);
        got++;
      end
      if (push8 && !full8) nxt++;
      step();
    end
    push8 = 1'b0; pop8 = 1'b0;
    check("stream_count", got, 100);
    check("stream_end_empty", 32'(empty8), 1);

    // Wrap-around on DEPTH=5 with random throttle
    nxt = 0; got = 0;
    for (int c = 0; c < 2000 && got < 23; c++) begin
      push5 = (nxt < 23) && ($urandom_range(0, 2) != 0);
      wdata5 = 8'(64 + nxt);
      pop5 = !empty5 && ($urandom_range(0, 2) != 0);
      #1;
      if (wen5) check("wrap_waddr_range", 32'(waddr5 > 3'd4), 0);
      if (ren5) check("wrap_raddr_range", 32'(raddr5 > 3'd4), 0);
      if (pop5) begin
        check("wrap_data", 32'(rdata5), 64 + got);
        got++;
      end
      if (push5 && !full5) nxt++;
      step();
    end
    push5 = 1'b0; pop5 = 1'b0;
    check("wrap_count", got, 23);

    // Push and pop together at full on DEPTH=4
    for (int i = 0; i < 4; i++) begin
      push4 = 1'b1; wdata4 = 8'(8'h21 + i);
      step();
    end
    push4 = 1'b0;
    check("full4_full", 32'(full4), 1);
    push4 = 1'b1; pop4 = 1'b1; wdata4 = 8'h77;
    #1;
    check("full4_pop_data", 32'(rdata4), 32'h21);
    check("full4_push_wen", 32'(wen4), 0);
    step();
    push4 = 1'b0; pop4 = 1'b0;
    check("full4_level", 32'(level4), 3);
    for (int i = 0; i < 3; i++) begin
      check("full4_drain", 32'(rdata4), 32'h22 + i);
      pop4 = 1'b1;
      step();
    end
    pop4 = 1'b0;
    check("full4_empty", 32'(empty4), 1);

    // Mid-operation reset with level 3 and a read in flight
    for (int i = 0; i < 3; i++) begin
      push8 = 1'b1; wdata8 = 8'(8'h31 + i);
      step();
    end
    wdata8 = 8'h34; pop8 = 1'b1;
    #1;
    check("mrst_ren", 32'(ren8), 1);
    step();
    push8 = 1'b0; pop8 = 1'b0;
    check("mrst_pre_level", 32'(level8), 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_empty", 32'(empty8), 1);
    check("mrst_level", 32'(level8), 0);
    check("mrst_rdata", 32'(rdata8), 0);
    push8 = 1'b1; wdata8 = 8'h11;
    step();
    push8 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (!empty8) seen = 1'b1;
      else step();
    end
    check("mrst_visible", 32'(seen), 1);
    check("mrst_data", 32'(rdata8), 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
